// File: rtl/wb_pkg.sv
// Shared defaults and types for the register-file writeback arbiter.
package wb_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_MEM  = 2'd2
  } src_sel_t;
endpackage

// File: rtl/wb_slot.sv
// One-entry holding register between a producer and the write-port arbiter.
module wb_slot #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain,
  output logic              slot_valid,
  output logic [ADDR_W-1:0] slot_reg,
  output logic [DATA_W-1:0] slot_data
);
  // A granted entry frees the slot this cycle, so a winner can refill back-to-back.
  assign in_ready = !reset && (!slot_valid || drain);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid <= 1'b0;
      slot_reg   <= '0;
      slot_data  <= '0;
    end else if (in_valid && in_ready) begin
      slot_valid <= 1'b1;
      slot_reg   <= in_reg;
      slot_data  <= in_data;
    end else if (drain) begin
      slot_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates ALU and load results onto the register file write port and tracks pending writes.
// Define WB_BYPASS_EN to add forwarding outputs for the write currently in flight.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_reg,
  input  logic [ADDR_W-1:0] q_reg_1,
  input  logic [ADDR_W-1:0] q_reg_2,
  output logic              q_busy_1,
  output logic              q_busy_2,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              idle
`ifdef WB_BYPASS_EN
  ,
  output logic              q_fwd_valid_1,
  output logic              q_fwd_valid_2,
  output logic [DATA_W-1:0] q_fwd_data_1,
  output logic [DATA_W-1:0] q_fwd_data_2
`endif
);
  localparam int NUM_SRC = 2;  // 0 = ALU, 1 = MEM
  localparam int NREG    = 2**ADDR_W;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [NUM_SRC-1:0]             src_valid, src_ready, drain, slot_v;
  logic [NUM_SRC-1:0][ADDR_W-1:0] src_reg, slot_reg;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_data, slot_data;

  assign src_valid = {mem_valid, alu_valid};
  assign src_reg   = {mem_reg, alu_reg};
  assign src_data  = {mem_data, alu_data};
  assign alu_ready = src_ready[0];
  assign mem_ready = src_ready[1];

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_slot
    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (src_valid[s]),
      .in_ready  (src_ready[s]),
      .in_reg    (src_reg[s]),
      .in_data   (src_data[s]),
      .drain     (drain[s]),
      .slot_valid(slot_v[s]),
      .slot_reg  (slot_reg[s]),
      .slot_data (slot_data[s])
    );
  end

  logic [3:0]        starve_cnt;
  src_sel_t          sel;
  logic [ADDR_W-1:0] win_reg;
  logic [DATA_W-1:0] win_data;

  always_comb begin
    sel = SRC_NONE;
    if (slot_v[0] && slot_v[1]) sel = (starve_cnt == LIM) ? SRC_MEM : SRC_ALU;
    else if (slot_v[0])         sel = SRC_ALU;
    else if (slot_v[1])         sel = SRC_MEM;
  end

  assign drain    = {sel == SRC_MEM, sel == SRC_ALU};
  assign win_reg  = (sel == SRC_MEM) ? slot_reg[1]  : slot_reg[0];
  assign win_data = (sel == SRC_MEM) ? slot_data[1] : slot_data[0];

  // Counts consecutive losses of a waiting load; any MEM grant or empty slot restarts it.
  always_ff @(posedge clk) begin
    if (reset)                         starve_cnt <= '0;
    else if (slot_v[1] && !drain[1])   starve_cnt <= (starve_cnt == LIM) ? starve_cnt : starve_cnt + 4'd1;
    else                               starve_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_enable <= 1'b0;
      rf_write_reg    <= '0;
      rf_write_data   <= '0;
    end else if (sel != SRC_NONE) begin
      rf_write_enable <= (win_reg != ADDR_W'(REG_ZERO));
      rf_write_reg    <= win_reg;
      rf_write_data   <= win_data;
    end else begin
      rf_write_enable <= 1'b0;
    end
  end

  logic [NREG-1:0] busy, busy_nxt;

  // Allocation is applied after the grant clear so a same-edge re-reservation survives.
  always_comb begin
    busy_nxt = busy;
    if (sel != SRC_NONE) busy_nxt[win_reg]   = 1'b0;
    if (alloc_valid)     busy_nxt[alloc_reg] = 1'b1;
    busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  assign q_busy_1 = busy[q_reg_1];
  assign q_busy_2 = busy[q_reg_2];
  assign idle     = !slot_v[0] && !slot_v[1] && !rf_write_enable;

`ifdef WB_BYPASS_EN
  assign q_fwd_valid_1 = rf_write_enable && (rf_write_reg == q_reg_1) && (q_reg_1 != ADDR_W'(REG_ZERO));
  assign q_fwd_valid_2 = rf_write_enable && (rf_write_reg == q_reg_2) && (q_reg_2 != ADDR_W'(REG_ZERO));
  assign q_fwd_data_1  = rf_write_data;
  assign q_fwd_data_2  = rf_write_data;
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed vector table plus hand sequences for contention, reset and bypass.
module tb_writeback_arbiter;
  logic        clk, reset;
  logic        alu_valid, alu_ready, mem_valid, mem_ready, alloc_valid;
  logic [4:0]  alu_reg, mem_reg, alloc_reg, q_reg_1, q_reg_2, rf_write_reg;
  logic [31:0] alu_data, mem_data, rf_write_data;
  logic        q_busy_1, q_busy_2, rf_write_enable, idle;
`ifdef WB_BYPASS_EN
  logic        q_fwd_valid_1, q_fwd_valid_2;
  logic [31:0] q_fwd_data_1, q_fwd_data_2;
`endif

  writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .alloc_valid(alloc_valid), .alloc_reg(alloc_reg),
    .q_reg_1(q_reg_1), .q_reg_2(q_reg_2), .q_busy_1(q_busy_1), .q_busy_2(q_busy_2),
    .rf_write_enable(rf_write_enable), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .idle(idle)
`ifdef WB_BYPASS_EN
    , .q_fwd_valid_1(q_fwd_valid_1), .q_fwd_valid_2(q_fwd_valid_2),
    .q_fwd_data_1(q_fwd_data_1), .q_fwd_data_2(q_fwd_data_2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic av; logic [4:0] areg; logic [31:0] adata;
    logic mv; logic [4:0] mreg; logic [31:0] mdata;
    logic lv; logic [4:0] lreg; logic [4:0] q1, q2;
    logic chk_rf;
    logic ar, mr, we; logic [4:0] wreg; logic [31:0] wdata;
    logic b1, b2, idl;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_in();
    alu_valid = 0; alu_reg = 0; alu_data = 0;
    mem_valid = 0; mem_reg = 0; mem_data = 0;
    alloc_valid = 0; alloc_reg = 0;
  endtask

  initial begin
    // av areg adata        mv mreg mdata     lv lreg q1 q2 rf  ar mr we wreg wdata         b1 b2 idle
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 0, 5, 0, 1,  1, 1, 0, 0, 32'h0,        0, 0, 1};
    vecs[1]  = '{0, 0, 0,            0, 0, 0,        0, 0, 5, 0, 1,  1, 1, 0, 0, 32'h0,        0, 0, 0};
    vecs[2]  = '{0, 0, 0,            0, 0, 0,        0, 0, 5, 0, 1,  1, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0};
    vecs[3]  = '{0, 0, 0,            0, 0, 0,        0, 0, 5, 0, 1,  1, 1, 0, 5, 32'hDEADBEEF, 0, 0, 1};
    vecs[4]  = '{0, 0, 0,            1, 0, 32'h1234, 0, 0, 0, 0, 1,  1, 1, 0, 5, 32'hDEADBEEF, 0, 0, 1};
    vecs[5]  = '{0, 0, 0,            0, 0, 0,        0, 0, 0, 0, 1,  1, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0};
    vecs[6]  = '{0, 0, 0,            0, 0, 0,        0, 0, 0, 0, 0,  1, 1, 0, 0, 32'h0,        0, 0, 1};
    vecs[7]  = '{0, 0, 0,            0, 0, 0,        1, 9, 9, 0, 0,  1, 1, 0, 0, 32'h0,        0, 0, 1};
    vecs[8]  = '{1, 9, 32'h99,       0, 0, 0,        0, 0, 9, 0, 0,  1, 1, 0, 0, 32'h0,        1, 0, 1};
    vecs[9]  = '{0, 0, 0,            0, 0, 0,        0, 0, 9, 9, 0,  1, 1, 0, 0, 32'h0,        1, 1, 0};
    vecs[10] = '{0, 0, 0,            0, 0, 0,        0, 0, 9, 9, 1,  1, 1, 1, 9, 32'h99,       0, 0, 0};
    vecs[11] = '{1, 9, 32'hAA,       0, 0, 0,        1, 9, 9, 0, 1,  1, 1, 0, 9, 32'h99,       0, 0, 1};
    vecs[12] = '{0, 0, 0,            0, 0, 0,        1, 9, 9, 0, 1,  1, 1, 0, 9, 32'h99,       1, 0, 0};
    vecs[13] = '{0, 0, 0,            0, 0, 0,        0, 0, 9, 0, 1,  1, 1, 1, 9, 32'hAA,       1, 0, 0};
    vecs[14] = '{0, 0, 0,            0, 0, 0,        1, 0, 9, 0, 1,  1, 1, 0, 9, 32'hAA,       1, 0, 1};
    vecs[15] = '{0, 0, 0,            0, 0, 0,        0, 0, 9, 0, 1,  1, 1, 0, 9, 32'hAA,       1, 0, 1};

    clear_in(); q_reg_1 = 0; q_reg_2 = 0;
    reset = 1;
    tick(); tick();
    chk("readies_in_reset", {alu_ready, mem_ready}, 2'b00);
    reset = 0; #1;
    chk("reset_state", {rf_write_enable, rf_write_reg, rf_write_data, q_busy_1, q_busy_2, idle, alu_ready, mem_ready},
        {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});

    for (int i = 0; i < 16; i++) begin
      alu_valid = vecs[i].av; alu_reg = vecs[i].areg; alu_data = vecs[i].adata;
      mem_valid = vecs[i].mv; mem_reg = vecs[i].mreg; mem_data = vecs[i].mdata;
      alloc_valid = vecs[i].lv; alloc_reg = vecs[i].lreg;
      q_reg_1 = vecs[i].q1; q_reg_2 = vecs[i].q2;
      #1;
      chk($sformatf("vec%0d_ctl", i), {alu_ready, mem_ready, rf_write_enable, q_busy_1, q_busy_2, idle},
          {vecs[i].ar, vecs[i].mr, vecs[i].we, vecs[i].b1, vecs[i].b2, vecs[i].idl});
      if (vecs[i].chk_rf)
        chk($sformatf("vec%0d_rf", i), {rf_write_reg, rf_write_data}, {vecs[i].wreg, vecs[i].wdata});
      tick();
    end

    // Contention: both producers offer every cycle; expect ALU,ALU,ALU,MEM repeating.
    clear_in();
    alu_valid = 1; alu_reg = 1; alu_data = 32'hA0A0;
    mem_valid = 1; mem_reg = 2; mem_data = 32'hB0B0;
    tick();
    for (int k = 1; k <= 12; k++) begin
      logic g;
      g = (k % 4 == 0);
      #1;
      chk($sformatf("cont%0d_ready", k), {alu_ready, mem_ready}, {!g, g});
      tick();
      chk($sformatf("cont%0d_grant", k), {rf_write_enable, rf_write_reg, rf_write_data},
          {1'b1, g ? 5'd2 : 5'd1, g ? 32'hB0B0 : 32'hA0A0});
    end

    // Reset with both slots holding results and reg 9 still reserved.
    clear_in(); q_reg_1 = 9; #1;
    chk("pre_reset_busy", {q_busy_1}, 1'b1);
    reset = 1; #1;
    chk("mid_reset_readies", {alu_ready, mem_ready}, 2'b00);
    tick();
    reset = 0; #1;
    chk("post_reset", {rf_write_enable, q_busy_1, idle, alu_ready, mem_ready}, 5'b00111);
    tick();
    chk("post_reset_nowrite", {rf_write_enable, idle}, 2'b01);

`ifdef WB_BYPASS_EN
    alu_valid = 1; alu_reg = 7; alu_data = 32'hCAFE; q_reg_2 = 7; q_reg_1 = 9;
    tick();
    clear_in();
    tick(); #1;
    chk("fwd2_hit", {q_fwd_valid_2, q_fwd_data_2, q_fwd_valid_1}, {1'b1, 32'hCAFE, 1'b0});
    q_reg_2 = 0; #1;
    chk("fwd2_reg0", {q_fwd_valid_2}, 1'b0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Write-side initiator for the 32x32 register file's single write port.
- Collects results from two producers, the ALU (single-cycle) and the load unit (MEM), each via a valid/ready handshake and a one-entry holding slot.
- Arbitrates the two slots onto the write port, with an anti-starvation counter for MEM.
- Keeps a pending-write scoreboard so the issue stage can detect RAW hazards on both read ports.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width (2**ADDR_W registers).
- STARVE_LIMIT, 3, consecutive lost arbitrations after which MEM gets priority; must be 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU slot can accept
- alu_reg  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  MEM slot can accept
- mem_reg  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- alloc_valid  in  1  issue stage reserves a destination
- alloc_reg  in  ADDR_W  register being reserved
- q_reg_1, q_reg_2  in  ADDR_W  hazard query indices (same values as register file reg_1/reg_2)
- q_busy_1, q_busy_2  out  1  queried register has a pending write
- rf_write_enable  out  1  to register file write_enable
- rf_write_reg  out  ADDR_W  to register file write_reg
- rf_write_data  out  DATA_W  to register file write_data
- idle  out  1  both slots empty and no write asserted

Behaviour:
- Reset values: slots empty; busy vector 0; starve_cnt 0; rf_write_enable 0; rf_write_reg 0; rf_write_data 0. alu_ready and mem_ready are 0 while reset is high. Reset mid-operation discards held results without writing them.
- Handshake: a transfer occurs at a clock edge where valid && ready. ready = !slot_valid || slot_granted_this_cycle, so a source sustains one transfer per cycle while it wins.
- Arbitration (combinational each cycle, over the slots):
  - Only one slot valid: it wins.
  - Both valid: ALU wins, unless starve_cnt == STARVE_LIMIT, in which case MEM wins.
- Grant edge:
  - rf_write_enable <= 1 and rf_write_reg/rf_write_data <= winner's fields; the winner's slot clears unless it is refilled at the same edge.
  - No winner: rf_write_enable <= 0; rf_write_reg/rf_write_data hold their values.
- Latency: handshake at edge t -> rf_write_enable high in cycle after edge t+1 (if granted) -> register file captures at edge t+2.
- Register 0: a granted slot with reg 0 is consumed but rf_write_enable <= 0 for that cycle. Register 0 is never marked busy.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, each cycle MEM slot valid and not granted.
  - Clears to 0 on MEM grant or when the MEM slot is empty.
- Scoreboard (busy[2**ADDR_W-1:1]):
  - alloc_valid sets busy[alloc_reg] at the edge.
  - A grant clears busy[winner reg] at the grant edge.
  - Same-edge set and clear of the same register: set wins (newer producer).
  - q_busy_n = busy[q_reg_n], combinational; always 0 for index 0.
- idle = !alu_slot_valid && !mem_slot_valid && !rf_write_enable.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: adds outputs q_fwd_valid_1/2 (1) and q_fwd_data_1/2 (DATA_W).
  - q_fwd_valid_n = rf_write_enable && rf_write_reg == q_reg_n && q_reg_n != 0.
  - q_fwd_data_n = rf_write_data.
  - Covers the cycle where the register file's registered read still returns stale data.
- Undefined: these ports do not exist; behaviour otherwise identical.

Decomposition:
- Package wb_pkg holds:
  - DATA_W and ADDR_W defaults.
  - REG_ZERO constant.
  - src_sel_t enum: SRC_NONE, SRC_ALU, SRC_MEM.
- Sub-module wb_slot (one-entry holding register with valid/ready and drain input), instantiated once per source.

Test Plan:
- ALU only: alu_reg=5, alu_data=0xDEADBEEF, handshake at edge 1 -> rf_write_enable=1, rf_write_reg=5, rf_write_data=0xDEADBEEF after edge 2; idle=1 after edge 3.
- Contention: ALU and MEM valid every cycle, STARVE_LIMIT=3 -> grant sequence ALU,ALU,ALU,MEM repeating; mem_ready low while MEM waits.
- Register 0: mem_reg=0, mem_data=0x1234 -> slot consumed, rf_write_enable stays 0; q_busy for reg 0 always 0.
- Scoreboard: alloc reg 9; q_reg_1=9 -> q_busy_1=1; ALU result for reg 9 granted -> q_busy_1=0 after grant edge. Alloc reg 9 on the grant edge -> q_busy_1 stays 1.
- Reset mid-operation: both slots full, assert reset one cycle -> no write issued, busy all 0, readies 0 during reset, 1 after.
- WB_BYPASS_EN: write reg 7 = 0xCAFE in flight with q_reg_2=7 -> q_fwd_valid_2=1, q_fwd_data_2=0xCAFE; q_reg_2=0 -> q_fwd_valid_2=0.
